fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode. It streams words from a 1-cycle-latency synchronous instruction memory and assembles one-word and two-word (opcode + immediate) instructions. It presents one complete instruction per cycle to decode under a stall handshake. Jump and interrupt redirects flush the queue and discard in-flight fetches; an interrupt also captures a return PC.

---
 rtl/fetch_prefetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch stage. It streams words from a 1-cycle-latency synchronous
// instruction memory into a DEPTH-entry prefetch queue of {word, pc} entries.
// It assembles one-word instructions and two-word instructions (opcode plus
// immediate) and presents one complete instruction per cycle to decode.
// Jump and interrupt redirects flush the queue and drop in-flight fetches. An
// interrupt also captures a return PC.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   imemReq       fetch request this cycle
//   imemAddr      word address of the request (current fetch PC)
//   imemData      memory word for the request issued in the previous cycle
//   stall         decode not accepting; head instruction is held
//   jumpBit       redirect fetch to branchIR
//   branchIR      jump/branch target
//   interruptBit  redirect fetch to intVector (wins over jumpBit)
//   intVector     interrupt handler address
//   instrValid    a complete instruction sits at the queue head
//   instruction   head opcode word (0 when not valid)
//   immediate     second word of a two-word instruction, else 0
//   samePc        address of the head instruction (0 when not valid)
//   nextPc        samePc+1 or samePc+2 (0 when not valid)
//   retPc         return address captured on the last interrupt
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  INSTR_WIDTH  = 16,
    parameter int                  DEPTH        = 4,
    parameter int                  IMM_BIT      = 11,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imemReq,
    output logic [PC_WIDTH-1:0]    imemAddr,
    input  logic [INSTR_WIDTH-1:0] imemData,
    input  logic                   stall,
    input  logic                   jumpBit,
    input  logic [PC_WIDTH-1:0]    branchIR,
    input  logic                   interruptBit,
    input  logic [PC_WIDTH-1:0]    intVector,
    output logic                   instrValid,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [INSTR_WIDTH-1:0] immediate,
    output logic [PC_WIDTH-1:0]    samePc,
    output logic [PC_WIDTH-1:0]    nextPc,
    output logic [PC_WIDTH-1:0]    retPc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage (data only, never reset)
    logic [INSTR_WIDTH-1:0] word_q [DEPTH];
    logic [PC_WIDTH-1:0]    pc_q   [DEPTH];

    // Control state
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                inflight_q;
    logic [PC_WIDTH-1:0] inflightPc_q;
    logic [PC_WIDTH-1:0] fetchPc_q;
    logic [PC_WIDTH-1:0] retPc_q;

    // Combinational helpers
    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic [CNT_W:0]         occ;
    logic [PTR_W-1:0]       headNext;
    logic [INSTR_WIDTH-1:0] headWord;
    logic                   twoWord;
    logic                   complete;
    logic                   push;
    logic [CNT_W-1:0]       pop_n;
    logic [PC_WIDTH-1:0]    retCapture_d;

    assign redirect = interruptBit | jumpBit;
    assign target   = interruptBit ? intVector : branchIR;

    // Reserve a slot for every outstanding request so a returning word can
    // always be pushed without overrunning the queue.
    assign occ     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign imemReq = (occ < (CNT_W + 1)'(DEPTH)) && !redirect;
    assign imemAddr = fetchPc_q;

    assign headNext = head_q + PTR_W'(1);
    assign headWord = word_q[head_q];
    assign twoWord  = headWord[IMM_BIT];

    // A two-word head needs its immediate already in the queue.
    assign complete = (count_q != '0) && (!twoWord || (count_q >= CNT_W'(2)));
    assign push     = inflight_q && !redirect;

    always_comb begin
        pop_n = '0;
        if (complete && !stall) begin
            pop_n = twoWord ? CNT_W'(2) : CNT_W'(1);
        end
    end

    // Return address: the oldest instruction not yet executed, which is the
    // queue head, else the word being fetched, else the next fetch address.
    always_comb begin
        retCapture_d = fetchPc_q;
        if (count_q != '0) begin
            retCapture_d = pc_q[head_q];
        end else if (inflight_q) begin
            retCapture_d = inflightPc_q;
        end
    end

    always_comb begin
        instrValid  = complete;
        instruction = '0;
        immediate   = '0;
        samePc      = '0;
        nextPc      = '0;
        if (complete) begin
            instruction = headWord;
            samePc      = pc_q[head_q];
            if (twoWord) begin
                immediate = word_q[headNext];
                nextPc    = pc_q[head_q] + PC_WIDTH'(2);
            end else begin
                nextPc    = pc_q[head_q] + PC_WIDTH'(1);
            end
        end
    end

    assign retPc = retPc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            fetchPc_q  <= RESET_VECTOR;
            retPc_q    <= '0;
        end else if (redirect) begin
            // Flush everything; stall has no effect on a redirect.
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            fetchPc_q  <= target;
            if (interruptBit) begin
                retPc_q <= retCapture_d;
            end
        end else begin
            head_q     <= head_q + PTR_W'(pop_n);
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            count_q    <= count_q + CNT_W'(push) - pop_n;
            inflight_q <= imemReq;
            if (imemReq) begin
                fetchPc_q <= fetchPc_q + PC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imemReq) begin
            inflightPc_q <= fetchPc_q;
        end
        if (push) begin
            word_q[tail_q] <= imemData;
            pc_q[tail_q]   <= inflightPc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;
    localparam int IMMB  = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [15:0] imemData;
    logic        stall = 1'b0;
    logic        jumpBit = 1'b0;
    logic [31:0] branchIR = '0;
    logic        interruptBit = 1'b0;
    logic [31:0] intVector = '0;
    logic        instrValid;
    logic [15:0] instruction;
    logic [15:0] immediate;
    logic [31:0] samePc;
    logic [31:0] nextPc;
    logic [31:0] retPc;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    logic [15:0] mem [256];

    fetch_prefetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .stall        (stall),
        .jumpBit      (jumpBit),
        .branchIR     (branchIR),
        .interruptBit (interruptBit),
        .intVector    (intVector),
        .instrValid   (instrValid),
        .instruction  (instruction),
        .immediate    (immediate),
        .samePc       (samePc),
        .nextPc       (nextPc),
        .retPc        (retPc)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one cycle of read latency
    always @(posedge clk) imemData <= mem[imemAddr[7:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mFpc = '0;
    logic [31:0] mPendPc = '0;
    logic [31:0] mRet = '0;
    bit          mPend = 1'b0;

    function automatic bit m_complete();
        if (mq.size() == 0) return 1'b0;
        if (!mq[0].w[IMMB]) return 1'b1;
        return mq.size() >= 2;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                mFpc  = '0;
                mPend = 1'b0;
                mRet  = '0;
            end else begin
                bit   redir;
                bit   req;
                ent_t e;
                redir = jumpBit || interruptBit;
                req   = ((mq.size() + int'(mPend)) < DEPTH) && !redir;
                if (redir) begin
                    if (interruptBit)
                        mRet = (mq.size() >= 1) ? mq[0].pc : (mPend ? mPendPc : mFpc);
                    mq.delete();
                    mPend = 1'b0;
                    mFpc  = interruptBit ? intVector : branchIR;
                end else begin
                    if (m_complete() && !stall) begin
                        int n;
                        n = mq[0].w[IMMB] ? 2 : 1;
                        for (int k = 0; k < n; k++) void'(mq.pop_front());
                    end
                    if (mPend) begin
                        e.w  = mem[mPendPc[7:0]];
                        e.pc = mPendPc;
                        mq.push_back(e);
                    end
                    if (req) begin
                        mPendPc = mFpc;
                        mFpc    = mFpc + 32'd1;
                        mPend   = 1'b1;
                    end else begin
                        mPend = 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle out of reset
    initial begin
        forever begin
            @(negedge clk);
            if (en && rst) begin
                bit          eValid;
                logic [15:0] eInstr, eImm;
                logic [31:0] eSame, eNext;
                bit          eReq;
                eValid = m_complete();
                eInstr = eValid ? mq[0].w : 16'h0;
                eImm   = (eValid && mq[0].w[IMMB]) ? mq[1].w : 16'h0;
                eSame  = eValid ? mq[0].pc : 32'h0;
                eNext  = eValid ? (mq[0].pc + (mq[0].w[IMMB] ? 32'd2 : 32'd1)) : 32'h0;
                eReq   = ((mq.size() + int'(mPend)) < DEPTH) && !(jumpBit || interruptBit);
                chk("m_imemReq", imemReq, eReq);
                chk("m_imemAddr", imemAddr, mFpc);
                chk("m_instrValid", instrValid, eValid);
                chk("m_instruction", instruction, eInstr);
                chk("m_immediate", immediate, eImm);
                chk("m_samePc", samePc, eSame);
                chk("m_nextPc", nextPc, eNext);
                chk("m_retPc", retPc, mRet);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        jumpBit = 1'b0;
        interruptBit = 1'b0;
        branchIR = '0;
        intVector = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        // Sequential stream 1,2,3,...
        for (int i = 0; i < 256; i++) mem[i] = 16'(i + 1);
        do_reset();
        en = 1'b1;
        #2;
        chk("c0_req", imemReq, 1);
        chk("c0_addr", imemAddr, 0);
        chk("c0_valid", instrValid, 0);
        cyc(); #2;
        chk("c1_valid", instrValid, 0);
        cyc(); #2;
        chk("c2_valid", instrValid, 1);
        chk("c2_samePc", samePc, 0);
        chk("c2_nextPc", nextPc, 1);
        chk("c2_instr", instruction, 16'h0001);
        chk("c2_imm", immediate, 0);
        cyc(); #2;
        chk("c3_samePc", samePc, 1);
        chk("c3_instr", instruction, 16'h0002);
        cyc(); #2;
        chk("c4_samePc", samePc, 2);
        chk("c4_instr", instruction, 16'h0003);

        // Two-word instruction at pc 0
        mem[0] = 16'h3811;
        mem[1] = 16'h0004;
        do_reset();
        cyc(); cyc(); #2;
        chk("tw_wait_valid", instrValid, 0);
        cyc(); #2;
        chk("tw_valid", instrValid, 1);
        chk("tw_instr", instruction, 16'h3811);
        chk("tw_imm", immediate, 16'h0004);
        chk("tw_samePc", samePc, 0);
        chk("tw_nextPc", nextPc, 2);
        cyc(); #2;
        chk("tw_next_samePc", samePc, 2);
        chk("tw_next_instr", instruction, 16'h0003);

        // Stall for 10 cycles, then drain
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        do_reset();
        stall = 1'b1;
        repeat (9) cyc();
        #2;
        chk("st_req", imemReq, 0);
        chk("st_valid", instrValid, 1);
        chk("st_samePc", samePc, 0);
        cyc();
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("drain_valid", instrValid, 1);
            chk("drain_samePc", samePc, 32'(k));
            cyc();
        end

        // Jump while count+inflight = DEPTH and stalled
        do_reset();
        stall = 1'b1;
        repeat (4) cyc();
        jumpBit = 1'b1;
        branchIR = 32'h40;
        #2;
        chk("jmp_req", imemReq, 0);
        cyc();
        jumpBit = 1'b0;
        #2;
        chk("jmp1_valid", instrValid, 0);
        chk("jmp1_addr", imemAddr, 32'h40);
        chk("jmp1_req", imemReq, 1);
        cyc(); #2;
        chk("jmp2_valid", instrValid, 0);
        cyc(); #2;
        chk("jmp3_valid", instrValid, 1);
        chk("jmp3_samePc", samePc, 32'h40);
        chk("jmp3_nextPc", nextPc, 32'h41);
        chk("jmp3_instr", instruction, 16'h0040);

        // Interrupt and jump together with head at pc 7
        cyc();
        jumpBit = 1'b1;
        branchIR = 32'h7;
        cyc();
        jumpBit = 1'b0;
        cyc(); cyc(); #2;
        chk("pre_int_samePc", samePc, 32'h7);
        interruptBit = 1'b1;
        jumpBit = 1'b1;
        branchIR = 32'h55;
        intVector = 32'h100;
        #2;
        chk("int_req", imemReq, 0);
        cyc();
        interruptBit = 1'b0;
        jumpBit = 1'b0;
        #2;
        chk("int_addr", imemAddr, 32'h100);
        chk("int_retPc", retPc, 32'h7);
        chk("int_valid", instrValid, 0);

        // Asynchronous reset mid-operation
        stall = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_retPc", retPc, 0);
        chk("rst_valid", instrValid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_imm", immediate, 0);
        chk("rst_samePc", samePc, 0);
        chk("rst_nextPc", nextPc, 0);

        // Randomized run against the model
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (c == 2000) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            stall        = ($urandom_range(0, 99) < 35);
            jumpBit      = ($urandom_range(0, 99) < 5);
            interruptBit = ($urandom_range(0, 99) < 3);
            branchIR     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            intVector    = $urandom;
        end
        cyc();
        stall = 1'b0;
        jumpBit = 1'b0;
        interruptBit = 1'b0;
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
